// File: rtl/event_relay_pkg.sv
// event_relay_pkg
//   Shared types and helpers for the event relay chain.
//   - state_e   : controller states (IDLE, RUN, FIN)
//   - pos_width : width of the stage position counter for a given stage count
package event_relay_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  // Position counter width; never narrower than one bit.
  function automatic int pos_width(input int n_stages);
    return (n_stages > 2) ? $clog2(n_stages) : 1;
  endfunction

endpackage

// File: rtl/event_hop_timer.sv
// event_hop_timer
//   Inter-hop delay counter. Loaded with the hop delay whenever a stage fires,
//   then counts down once per cycle while running. fire_o is high while running
//   and the count has reached zero, meaning the next stage may fire at the
//   coming edge. The count parks at zero, it never wraps.
// Ports
//   clk        : clock
//   rst        : synchronous reset, active-high
//   load_i     : reload the counter with load_val_i
//   load_val_i : delay value to load (idle cycles between hops)
//   run_i      : chain is running; enables counting and fire_o
//   fire_o     : next hop due at the coming edge
module event_hop_timer #(
  parameter int DELAY_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [DELAY_W-1:0] load_val_i,
  input  logic               run_i,
  output logic               fire_o
);

  logic [DELAY_W-1:0] cnt_r;

  // Delay countdown register: reload on hop, decrement toward zero otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (load_i) begin
      cnt_r <= load_val_i;
    end else if (run_i && (cnt_r != '0)) begin
      cnt_r <= cnt_r - DELAY_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign fire_o = run_i && (cnt_r == '0);

endmodule

// File: rtl/event_relay_chain.sv
// event_relay_chain
//   A single token hops through N_STAGES stages with a programmable number of
//   idle cycles (D, latched on start) between hops. Each firing raises a
//   one-cycle strobe and a sticky triggered flag. In ring mode the token wraps
//   from the last stage to stage 0 until LAPS laps are complete.
// Ports
//   clk        : clock
//   rst        : synchronous reset, active-high
//   start_i    : inject token at stage 0 (accepted only in IDLE)
//   abort_i    : terminate a running chain
//   clr_i      : clear all sticky triggered flags
//   delay_i    : idle cycles between hops, sampled on accepted start
//   pulse_o    : one-hot strobe, stage k fires this cycle
//   trig_o     : sticky flags, stage k has fired since last clear
//   all_trig_o : every stage flag set
//   busy_o     : chain running
//   done_o     : one-cycle pulse on normal completion
//   aborted_o  : one-cycle pulse on abort completion
//   laps_o     : completed laps (ring mode), held until next accepted start
module event_relay_chain
  import event_relay_pkg::*;
#(
  parameter int N_STAGES = 100,
  parameter int DELAY_W  = 4,
  parameter int RING     = 0,
  parameter int LAPS     = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic                      abort_i,
  input  logic                      clr_i,
  input  logic [DELAY_W-1:0]        delay_i,
  output logic [N_STAGES-1:0]       pulse_o,
  output logic [N_STAGES-1:0]       trig_o,
  output logic                      all_trig_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      aborted_o,
  output logic [$clog2(LAPS+1)-1:0] laps_o
);

  localparam int                  POS_W     = pos_width(N_STAGES);
  localparam int                  LAP_W     = $clog2(LAPS + 1);
  localparam logic [POS_W-1:0]    LAST_POS  = POS_W'(N_STAGES - 1);
  localparam logic [LAP_W-1:0]    LAPS_MAX  = LAP_W'(LAPS);
  localparam logic [LAP_W:0]      LAPS_WIDE = (LAP_W + 1)'(LAPS);
  localparam logic [N_STAGES-1:0] ONE_HOT0  = {{(N_STAGES - 1){1'b0}}, 1'b1};

  state_e              state_r, state_d_s;
  logic [POS_W-1:0]    pos_r, pos_d_s;
  logic [DELAY_W-1:0]  d_r, d_d_s;
  logic [LAP_W-1:0]    laps_r, laps_d_s;
  logic [N_STAGES-1:0] pulse_r, pulse_d_s;
  logic [N_STAGES-1:0] trig_r, trig_d_s;
  logic                all_trig_r;
  logic                busy_r;
  logic                done_r, done_d_s;
  logic                aborted_r, aborted_d_s;
  logic                hop_load_s;
  logic [DELAY_W-1:0]  hop_val_s;
  logic                hop_fire_s;
  logic                run_s;
  logic [LAP_W:0]      lap_total_s;

  assign run_s = (state_r == RUN);

  // Laps completed including one that finishes on the strobe visible now;
  // lets a D=0 wrap decide before laps_r has caught up.
  assign lap_total_s = {1'b0, laps_r} + {{LAP_W{1'b0}}, pulse_r[N_STAGES-1]};

  event_hop_timer #(
    .DELAY_W(DELAY_W)
  ) u_hop_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (hop_load_s),
    .load_val_i(hop_val_s),
    .run_i     (run_s),
    .fire_o    (hop_fire_s)
  );

  // Next-state, hop and strobe decode.
  always_comb begin
    state_d_s   = state_r;
    pos_d_s     = pos_r;
    d_d_s       = d_r;
    laps_d_s    = laps_r;
    pulse_d_s   = '0;
    done_d_s    = 1'b0;
    aborted_d_s = 1'b0;
    hop_load_s  = 1'b0;
    hop_val_s   = d_r;
    case (state_r)
      IDLE: begin
        if (start_i) begin
          state_d_s  = RUN;
          pos_d_s    = '0;
          d_d_s      = delay_i;
          laps_d_s   = '0;
          pulse_d_s  = ONE_HOT0;
          hop_load_s = 1'b1;
          hop_val_s  = delay_i;
        end else begin
          state_d_s = IDLE;
        end
      end
      RUN: begin
        // A lap completes when the last stage strobe is visible.
        if ((RING != 0) && pulse_r[N_STAGES-1]) begin
          laps_d_s = laps_r + LAP_W'(1);
        end else begin
          laps_d_s = laps_r;
        end
        if (abort_i) begin
          state_d_s   = FIN;
          aborted_d_s = 1'b1;
        end else if ((RING != 0) ? (laps_r == LAPS_MAX) : pulse_r[N_STAGES-1]) begin
          state_d_s = FIN;
          done_d_s  = 1'b1;
        end else if (hop_fire_s) begin
          if (pos_r != LAST_POS) begin
            pos_d_s    = pos_r + POS_W'(1);
            pulse_d_s  = ONE_HOT0 << pos_d_s;
            hop_load_s = 1'b1;
          end else if ((RING != 0) && (lap_total_s < LAPS_WIDE)) begin
            pos_d_s    = '0;
            pulse_d_s  = ONE_HOT0;
            hop_load_s = 1'b1;
          end else begin
            // Final lap finished; wait for laps_r to reach LAPS.
            pos_d_s = pos_r;
          end
        end else begin
          state_d_s = RUN;
        end
      end
      FIN: begin
        state_d_s = IDLE;
      end
      default: begin
        state_d_s = IDLE;
      end
    endcase
    // Clear first, then OR in the stage firing at this edge so it survives.
    if (clr_i) begin
      trig_d_s = pulse_d_s;
    end else begin
      trig_d_s = trig_r | pulse_d_s;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      pos_r      <= '0;
      d_r        <= '0;
      laps_r     <= '0;
      pulse_r    <= '0;
      trig_r     <= '0;
      all_trig_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      aborted_r  <= 1'b0;
    end else begin
      state_r    <= state_d_s;
      pos_r      <= pos_d_s;
      d_r        <= d_d_s;
      laps_r     <= laps_d_s;
      pulse_r    <= pulse_d_s;
      trig_r     <= trig_d_s;
      all_trig_r <= &trig_d_s;
      busy_r     <= (state_d_s == RUN);
      done_r     <= done_d_s;
      aborted_r  <= aborted_d_s;
    end
  end

  assign pulse_o    = pulse_r;
  assign trig_o     = trig_r;
  assign all_trig_o = all_trig_r;
  assign busy_o     = busy_r;
  assign done_o     = done_r;
  assign aborted_o  = aborted_r;
  assign laps_o     = laps_r;

endmodule

// File: tb/tb_event_relay_chain.sv
// tb_event_relay_chain
//   Directed bench for event_relay_chain using three instances:
//   u_long (100 stages, one-shot), u_short (8 stages, one-shot) and
//   u_ring (4 stages, ring, 2 laps). Cycle 0 is the cycle start_i is driven;
//   outputs are sampled 1 time unit after each rising edge.
module tb_event_relay_chain;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic abort_i = 1'b0;
  logic clr_i = 1'b0;
  logic [3:0] delay_i = 4'd0;
  logic start_l = 1'b0;
  logic start_s = 1'b0;
  logic start_r = 1'b0;

  logic [99:0] pulse_l, trig_l;
  logic all_l, busy_l, done_l, abt_l;
  logic [1:0] laps_l;
  logic [7:0] pulse_s, trig_s;
  logic all_s, busy_s, done_s, abt_s;
  logic [1:0] laps_s;
  logic [3:0] pulse_r, trig_r;
  logic all_r, busy_r, done_r, abt_r;
  logic [1:0] laps_r;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  event_relay_chain #(.N_STAGES(100), .DELAY_W(4), .RING(0), .LAPS(2)) u_long (
    .clk(clk), .rst(rst), .start_i(start_l), .abort_i(abort_i), .clr_i(clr_i),
    .delay_i(delay_i), .pulse_o(pulse_l), .trig_o(trig_l), .all_trig_o(all_l),
    .busy_o(busy_l), .done_o(done_l), .aborted_o(abt_l), .laps_o(laps_l));

  event_relay_chain #(.N_STAGES(8), .DELAY_W(4), .RING(0), .LAPS(2)) u_short (
    .clk(clk), .rst(rst), .start_i(start_s), .abort_i(abort_i), .clr_i(clr_i),
    .delay_i(delay_i), .pulse_o(pulse_s), .trig_o(trig_s), .all_trig_o(all_s),
    .busy_o(busy_s), .done_o(done_s), .aborted_o(abt_s), .laps_o(laps_s));

  event_relay_chain #(.N_STAGES(4), .DELAY_W(4), .RING(1), .LAPS(2)) u_ring (
    .clk(clk), .rst(rst), .start_i(start_r), .abort_i(abort_i), .clr_i(clr_i),
    .delay_i(delay_i), .pulse_o(pulse_r), .trig_o(trig_r), .all_trig_o(all_r),
    .busy_o(busy_r), .done_o(done_r), .aborted_o(abt_r), .laps_o(laps_r));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_checks++;
    if ({pulse_l, trig_l, all_l, busy_l, done_l, abt_l, laps_l} !== 206'd0) begin
      n_fail++; $display("FAIL reset_long: got %0h want 0", {pulse_l, trig_l, all_l, busy_l, done_l, abt_l, laps_l});
    end
    n_checks++;
    if ({pulse_s, trig_s, all_s, busy_s, done_s, abt_s, laps_s} !== 22'd0) begin
      n_fail++; $display("FAIL reset_short: got %0h want 0", {pulse_s, trig_s, all_s, busy_s, done_s, abt_s, laps_s});
    end
    n_checks++;
    if ({pulse_r, trig_r, all_r, busy_r, done_r, abt_r, laps_r} !== 14'd0) begin
      n_fail++; $display("FAIL reset_ring: got %0h want 0", {pulse_r, trig_r, all_r, busy_r, done_r, abt_r, laps_r});
    end
    rst = 1'b0;
    step();
  endtask

  // 100 stages, D=0: strobes at cycles 1..100, done at 101.
  task automatic test_long_chain();
    logic [99:0] exp_p;
    delay_i = 4'd0;
    start_l = 1'b1;
    for (int cyc = 1; cyc <= 102; cyc++) begin
      step();
      start_l = 1'b0;
      exp_p = '0;
      if (cyc <= 100) exp_p[cyc-1] = 1'b1;
      n_checks++;
      if (pulse_l !== exp_p) begin
        n_fail++; $display("FAIL long_pulse c%0d: got %0h want %0h", cyc, pulse_l, exp_p);
      end
      n_checks++;
      if (done_l !== (cyc == 101)) begin
        n_fail++; $display("FAIL long_done c%0d: got %0b want %0b", cyc, done_l, cyc == 101);
      end
      n_checks++;
      if (busy_l !== (cyc <= 100)) begin
        n_fail++; $display("FAIL long_busy c%0d: got %0b want %0b", cyc, busy_l, cyc <= 100);
      end
      if (cyc == 99 || cyc == 101) begin
        n_checks++;
        if (all_l !== (cyc == 101)) begin
          n_fail++; $display("FAIL long_all_trig c%0d: got %0b want %0b", cyc, all_l, cyc == 101);
        end
      end
    end
  endtask

  // 8 stages, D=3: strobes at 1,5,...,29, done at 30; delay_i change mid-run ignored.
  task automatic test_delay();
    logic [7:0] exp_p;
    delay_i = 4'd3;
    start_s = 1'b1;
    for (int cyc = 1; cyc <= 31; cyc++) begin
      step();
      start_s = 1'b0;
      if (cyc == 2) delay_i = 4'd0;
      exp_p = 8'h00;
      if (cyc <= 29 && ((cyc - 1) % 4) == 0) exp_p[(cyc-1)/4] = 1'b1;
      n_checks++;
      if (pulse_s !== exp_p) begin
        n_fail++; $display("FAIL delay_pulse c%0d: got %0h want %0h", cyc, pulse_s, exp_p);
      end
      n_checks++;
      if (done_s !== (cyc == 30)) begin
        n_fail++; $display("FAIL delay_done c%0d: got %0b want %0b", cyc, done_s, cyc == 30);
      end
      if (cyc == 30) begin
        n_checks++;
        if (trig_s !== 8'hFF || all_s !== 1'b1) begin
          n_fail++; $display("FAIL delay_trig: got %0h/%0b want ff/1", trig_s, all_s);
        end
      end
    end
  endtask

  // 8 stages, D=2, start+clr together; abort in the pulse_o[3] cycle with start held.
  task automatic test_abort();
    logic [7:0] exp_p;
    delay_i = 4'd2;
    start_s = 1'b1;
    clr_i = 1'b1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      step();
      clr_i = 1'b0;
      abort_i = 1'b0;
      if (cyc == 1 || cyc == 12) start_s = 1'b0;
      exp_p = 8'h00;
      if (cyc <= 10 && ((cyc - 1) % 3) == 0) exp_p[(cyc-1)/3] = 1'b1;
      n_checks++;
      if (pulse_s !== exp_p) begin
        n_fail++; $display("FAIL abort_pulse c%0d: got %0h want %0h", cyc, pulse_s, exp_p);
      end
      n_checks++;
      if (abt_s !== (cyc == 11) || done_s !== 1'b0) begin
        n_fail++; $display("FAIL abort_flags c%0d: got aborted=%0b done=%0b want aborted=%0b done=0", cyc, abt_s, done_s, cyc == 11);
      end
      n_checks++;
      if (busy_s !== (cyc <= 10)) begin
        n_fail++; $display("FAIL abort_busy c%0d: got %0b want %0b", cyc, busy_s, cyc <= 10);
      end
      if (cyc == 1 || cyc == 11 || cyc == 20) begin
        n_checks++;
        if (trig_s !== ((cyc == 1) ? 8'h01 : 8'h0F)) begin
          n_fail++; $display("FAIL abort_trig c%0d: got %0h want %0h", cyc, trig_s, (cyc == 1) ? 8'h01 : 8'h0F);
        end
      end
      if (cyc == 10) begin
        abort_i = 1'b1;
        start_s = 1'b1;
      end
    end
  endtask

  // 8 stages, D=0; clr at the edge registering stage 5, then start+clr in IDLE.
  task automatic test_clear();
    logic [7:0] exp_p;
    logic [7:0] exp_t;
    delay_i = 4'd0;
    start_s = 1'b1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      step();
      start_s = 1'b0;
      clr_i = 1'b0;
      exp_p = 8'h00;
      if (cyc <= 8) exp_p[cyc-1] = 1'b1;
      if (cyc >= 11 && cyc <= 18) exp_p[cyc-11] = 1'b1;
      if (cyc <= 4) exp_t = 8'h0F;
      else if (cyc == 5) exp_t = 8'h1F;
      else if (cyc == 6) exp_t = 8'h20;
      else if (cyc == 7) exp_t = 8'h60;
      else if (cyc <= 10) exp_t = 8'hE0;
      else if (cyc <= 18) exp_t = 8'hFF >> (18 - cyc);
      else exp_t = 8'hFF;
      n_checks++;
      if (pulse_s !== exp_p) begin
        n_fail++; $display("FAIL clear_pulse c%0d: got %0h want %0h", cyc, pulse_s, exp_p);
      end
      n_checks++;
      if (trig_s !== exp_t) begin
        n_fail++; $display("FAIL clear_trig c%0d: got %0h want %0h", cyc, trig_s, exp_t);
      end
      n_checks++;
      if (done_s !== (cyc == 9 || cyc == 19)) begin
        n_fail++; $display("FAIL clear_done c%0d: got %0b want %0b", cyc, done_s, cyc == 9 || cyc == 19);
      end
      if (cyc == 5) clr_i = 1'b1;
      if (cyc == 10) begin
        start_s = 1'b1;
        clr_i = 1'b1;
      end
    end
  endtask

  // Ring, 4 stages, LAPS=2, D=1: stage-0 strobes at 1 and 9, done at 17.
  task automatic test_ring();
    logic [3:0] exp_p;
    logic [1:0] exp_l;
    int strobes;
    strobes = 0;
    delay_i = 4'd1;
    start_r = 1'b1;
    for (int cyc = 1; cyc <= 18; cyc++) begin
      step();
      start_r = 1'b0;
      exp_p = 4'h0;
      if (cyc <= 15 && (cyc % 2) == 1) exp_p[((cyc-1)/2) % 4] = 1'b1;
      exp_l = (cyc < 8) ? 2'd0 : ((cyc < 16) ? 2'd1 : 2'd2);
      if (pulse_r != 4'h0) strobes++;
      n_checks++;
      if (pulse_r !== exp_p) begin
        n_fail++; $display("FAIL ring_pulse c%0d: got %0h want %0h", cyc, pulse_r, exp_p);
      end
      n_checks++;
      if (laps_r !== exp_l) begin
        n_fail++; $display("FAIL ring_laps c%0d: got %0d want %0d", cyc, laps_r, exp_l);
      end
      n_checks++;
      if (done_r !== (cyc == 17) || busy_r !== (cyc <= 16)) begin
        n_fail++; $display("FAIL ring_done_busy c%0d: got done=%0b busy=%0b want done=%0b busy=%0b", cyc, done_r, busy_r, cyc == 17, cyc <= 16);
      end
    end
    n_checks++;
    if (strobes !== 8) begin
      n_fail++; $display("FAIL ring_strobe_count: got %0d want 8", strobes);
    end
    n_checks++;
    if (trig_r !== 4'hF || all_r !== 1'b1) begin
      n_fail++; $display("FAIL ring_trig: got %0h/%0b want f/1", trig_r, all_r);
    end
  endtask

  // Reset in the middle of a ring run, then a fresh run from stage 0.
  task automatic test_reset_mid();
    delay_i = 4'd1;
    start_r = 1'b1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      step();
      start_r = 1'b0;
    end
    n_checks++;
    if (laps_r !== 2'd1 || busy_r !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_pre: got laps=%0d busy=%0b want laps=1 busy=1", laps_r, busy_r);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if ({pulse_r, trig_r, all_r, busy_r, done_r, abt_r, laps_r} !== 14'd0) begin
      n_fail++; $display("FAIL rstmid_outputs: got %0h want 0", {pulse_r, trig_r, all_r, busy_r, done_r, abt_r, laps_r});
    end
    n_checks++;
    if (trig_s !== 8'h00) begin
      n_fail++; $display("FAIL rstmid_short_trig: got %0h want 0", trig_s);
    end
    for (int cyc = 0; cyc < 3; cyc++) begin
      step();
      n_checks++;
      if (done_r !== 1'b0 || abt_r !== 1'b0 || busy_r !== 1'b0) begin
        n_fail++; $display("FAIL rstmid_quiet: got done=%0b aborted=%0b busy=%0b want 0/0/0", done_r, abt_r, busy_r);
      end
    end
    start_r = 1'b1;
    for (int cyc = 1; cyc <= 17; cyc++) begin
      step();
      start_r = 1'b0;
      if (cyc == 1) begin
        n_checks++;
        if (pulse_r !== 4'h1 || laps_r !== 2'd0 || busy_r !== 1'b1) begin
          n_fail++; $display("FAIL rstmid_restart: got pulse=%0h laps=%0d busy=%0b want 1/0/1", pulse_r, laps_r, busy_r);
        end
      end
      if (cyc == 17) begin
        n_checks++;
        if (done_r !== 1'b1 || laps_r !== 2'd2) begin
          n_fail++; $display("FAIL rstmid_done: got done=%0b laps=%0d want 1/2", done_r, laps_r);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_long_chain();
    test_delay();
    test_abort();
    test_clear();
    test_ring();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
